// File: rtl/pc_stack_ctr_pkg.sv
// Shared defaults and the one-hot op-select encoding for the program counter with return stack.
package pc_stack_ctr_pkg;

  localparam int unsigned PC_W_DEF  = 16;
  localparam int unsigned OFS_W_DEF = 10;
  localparam int unsigned DEPTH_DEF = 8;
  localparam logic [15:0] RESET_VEC_DEF = 16'hFFF0;

  typedef enum logic [4:0] {
    OP_NONE = 5'b00000,
    OP_LOAD = 5'b00001,
    OP_CALL = 5'b00010,
    OP_RET  = 5'b00100,
    OP_REL  = 5'b01000,
    OP_INC  = 5'b10000
  } op_e;

  // Fixed priority: load > call > ret > rel > inc; strobes are active-low.
  function automatic op_e op_decode(input logic nwpc, input logic ncall, input logic nret,
                                    input logic nrel, input logic nincpc);
    if (!nwpc)   return OP_LOAD;
    if (!ncall)  return OP_CALL;
    if (!nret)   return OP_RET;
    if (!nrel)   return OP_REL;
    if (!nincpc) return OP_INC;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// DEPTH x W return-address LIFO; a push when full or pop when empty sets a sticky error.
module pc_ret_stack
  import pc_stack_ctr_pkg::*;
#(
  parameter int unsigned W     = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH):0]     depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          wr_en;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign err_o   = err_q;
  assign dout_o  = mem_q[AW'(depth_q - DW'(1))];

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (push_i) begin
      if (full_o) begin
        err_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        depth_d = depth_q + DW'(1);
      end
    end else if (pop_i) begin
      if (empty_o) err_d = 1'b1;
      else         depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; entries above depth are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[depth_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pc_stack_ctr.sv
// Program counter with relative branch, call/return stack and tri-state IBUS readout.
// Optional sticky wrap flag output pc_wrap when PC_WRAP_FLAG_EN is defined.
module pc_stack_ctr
  import pc_stack_ctr_pkg::*;
#(
  parameter int unsigned W         = PC_W_DEF,
  parameter logic [W-1:0] RESET_VEC = W'(RESET_VEC_DEF),
  parameter int unsigned OFS_W     = OFS_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   nrpc,
  input  logic                   nwpc,
  input  logic                   nincpc,
  input  logic                   nrel,
  input  logic                   ncall,
  input  logic                   nret,
  inout  wire  [W-1:0]           ibus,
  output logic [W-1:0]           pc,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   stk_empty,
  output logic                   stk_full,
`ifdef PC_WRAP_FLAG_EN
  output logic                   pc_wrap,
`endif
  output logic                   stk_err
);

  op_e          op;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] bus_in;
  logic [W-1:0] ofs_ext;
  logic [W-1:0] rel_sum;
  logic [W-1:0] stk_top;
  logic         push, pop;

  assign ibus = nrpc ? {W{1'bz}} : pc_q;
  // While we drive the bus, loads see our own value.
  assign bus_in  = nrpc ? ibus : pc_q;
  assign ofs_ext = W'($signed(bus_in[OFS_W-1:0]));
  assign op      = op_decode(nwpc, ncall, nret, nrel, nincpc);
  assign pc      = pc_q;

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    unique case (op)
      OP_LOAD: pc_d = bus_in;
      OP_CALL: begin
        push = 1'b1;
        if (!stk_full) pc_d = bus_in;
      end
      OP_RET: begin
        pop = 1'b1;
        if (!stk_empty) pc_d = stk_top;
      end
      OP_REL:  pc_d = rel_sum;
      OP_INC:  pc_d = pc_q + W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) pc_q <= RESET_VEC;
    else         pc_q <= pc_d;
  end

`ifdef PC_WRAP_FLAG_EN
  logic [W:0] rel_full;
  logic       wrap_q, wrap_d;

  assign rel_full = {1'b0, pc_q} + {1'b0, ofs_ext};
  assign rel_sum  = rel_full[W-1:0];
  assign pc_wrap  = wrap_q;

  // Carry out with a positive offset, or no carry with a negative one, means the 2^W boundary was crossed.
  always_comb begin
    wrap_d = wrap_q;
    if (op == OP_LOAD)                                 wrap_d = 1'b0;
    else if (op == OP_INC && (&pc_q))                  wrap_d = 1'b1;
    else if (op == OP_REL && (rel_full[W] ^ ofs_ext[W-1])) wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) wrap_q <= 1'b0;
    else         wrap_q <= wrap_d;
  end
`else
  assign rel_sum = pc_q + ofs_ext;
`endif

  pc_ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_q + W'(1)),
    .dout_o  (stk_top),
    .depth_o (depth),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .err_o   (stk_err)
  );

endmodule

// File: tb/tb_pc_stack_ctr.sv
// Scoreboard bench for pc_stack_ctr: directed steps queue expectations, a monitor checks them.
module tb_pc_stack_ctr;

  logic        clk = 1'b0;
  logic        nreset, nrpc, nwpc, nincpc, nrel, ncall, nret;
  logic        bus_en;
  logic [15:0] bus_drv;
  wire  [15:0] ibus;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        stk_empty, stk_full, stk_err;
`ifdef PC_WRAP_FLAG_EN
  logic        pc_wrap;
`endif

  assign ibus = bus_en ? bus_drv : 16'hzzzz;

  always #5 clk = ~clk;

  pc_stack_ctr dut (
    .clk       (clk),
    .nreset    (nreset),
    .nrpc      (nrpc),
    .nwpc      (nwpc),
    .nincpc    (nincpc),
    .nrel      (nrel),
    .ncall     (ncall),
    .nret      (nret),
    .ibus      (ibus),
    .pc        (pc),
    .depth     (depth),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
`ifdef PC_WRAP_FLAG_EN
    .pc_wrap   (pc_wrap),
`endif
    .stk_err   (stk_err)
  );

  typedef struct {
    string       nm;
    logic [15:0] pc;
    int unsigned dep;
    logic        err;
    logic        wrap;
    logic        chk_bus;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [15:0] epc, input int unsigned edep,
                          input logic eerr, input logic ewrap, input logic chk_bus);
    exp_t e;
    e.nm = nm; e.pc = epc; e.dep = edep; e.err = eerr; e.wrap = ewrap; e.chk_bus = chk_bus;
    sb.push_back(e);
  endtask

  // Outputs settle after a clock edge or an asynchronous reset assertion.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk or negedge nreset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp({e.nm, ".pc"},    pc,              e.pc);
        cmp({e.nm, ".depth"}, 16'(depth),      16'(e.dep));
        cmp({e.nm, ".empty"}, 16'(stk_empty),  16'(e.dep == 0));
        cmp({e.nm, ".full"},  16'(stk_full),   16'(e.dep == 8));
        cmp({e.nm, ".err"},   16'(stk_err),    16'(e.err));
`ifdef PC_WRAP_FLAG_EN
        cmp({e.nm, ".wrap"},  16'(pc_wrap),    16'(e.wrap));
`endif
        if (e.chk_bus) cmp({e.nm, ".ibus"}, ibus, e.pc);
      end
    end
  end

  // Strobes are given active-high here and inverted onto the pins.
  task automatic step(input string nm, input logic w, input logic c, input logic r,
                      input logic rl, input logic inc, input logic rd, input logic [15:0] bus,
                      input logic [15:0] epc, input int unsigned edep, input logic eerr,
                      input logic ewrap);
    @(negedge clk);
    nwpc = !w; ncall = !c; nret = !r; nrel = !rl; nincpc = !inc; nrpc = !rd;
    bus_en  = !rd;
    bus_drv = bus;
    push_exp(nm, epc, edep, eerr, ewrap, rd);
  endtask

  task automatic idle();
    @(negedge clk);
    nwpc = 1'b1; ncall = 1'b1; nret = 1'b1; nrel = 1'b1; nincpc = 1'b1; nrpc = 1'b1;
    bus_en = 1'b0;
  endtask

  initial begin
    nreset = 1'b1;
    nwpc = 1'b1; ncall = 1'b1; nret = 1'b1; nrel = 1'b1; nincpc = 1'b1; nrpc = 1'b1;
    bus_en = 1'b0; bus_drv = 16'h0000;

    #2;
    push_exp("reset", 16'hFFF0, 0, 1'b0, 1'b0, 1'b0);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;

    step("inc1", 0,0,0,0,1,0, 16'h0000, 16'hFFF1, 0, 0, 0);
    step("inc2", 0,0,0,0,1,0, 16'h0000, 16'hFFF2, 0, 0, 0);
    step("inc3", 0,0,0,0,1,0, 16'h0000, 16'hFFF3, 0, 0, 0);
    step("read", 0,0,0,0,0,1, 16'h0000, 16'hFFF3, 0, 0, 0);

    step("ld_ffff",  1,0,0,0,0,0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("inc_wrap", 0,0,0,0,1,0, 16'h0000, 16'h0000, 0, 0, 1);
    step("ld_0100",  1,0,0,0,0,0, 16'h0100, 16'h0100, 0, 0, 0);
    step("rel_m16",  0,0,0,1,0,0, 16'h03F0, 16'h00F0, 0, 0, 0);
    step("rel_p16",  0,0,0,1,0,0, 16'h0010, 16'h0100, 0, 0, 0);
    step("rel_hi",   0,0,0,1,0,0, 16'hFC10, 16'h0110, 0, 0, 0);
    step("ld_0005",  1,0,0,0,0,0, 16'h0005, 16'h0005, 0, 0, 0);
    step("rel_neg",  0,0,0,1,0,0, 16'h03F0, 16'hFFF5, 0, 0, 1);
    step("ld_0200",  1,0,0,0,0,0, 16'h0200, 16'h0200, 0, 0, 0);
    step("call1",    0,1,0,0,0,0, 16'h1000, 16'h1000, 1, 0, 0);
    step("ret1",     0,0,1,0,0,0, 16'h0000, 16'h0201, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      step($sformatf("call_f%0d", i), 0,1,0,0,0,0, 16'h1000 + 16'(i) * 16'h0100,
           16'h1000 + 16'(i) * 16'h0100, i + 1, 0, 0);
    step("call_ovf", 0,1,0,0,0,0, 16'h2000, 16'h1700, 8, 1, 0);
    for (int j = 0; j < 8; j++)
      step($sformatf("ret_f%0d", j), 0,0,1,0,0,0, 16'h0000,
           (j == 7) ? 16'h0202 : 16'h1601 - 16'(j) * 16'h0100, 7 - j, 1, 0);
    step("ret_udf",  0,0,1,0,0,0, 16'h0000, 16'h0202, 0, 1, 0);

    step("rd_wpc",   1,0,0,0,0,1, 16'h0000, 16'h0202, 0, 1, 0);
    step("pri_wci",  1,1,0,0,1,0, 16'h4000, 16'h4000, 0, 1, 0);
    step("pri_cr",   0,1,1,0,0,0, 16'h5000, 16'h5000, 1, 1, 0);
    step("pri_rri",  0,0,1,1,1,0, 16'h0000, 16'h4001, 0, 1, 0);
    step("pri_ri",   0,0,0,1,1,0, 16'h0002, 16'h4003, 0, 1, 0);
    step("call_pre", 0,1,0,0,0,0, 16'h6000, 16'h6000, 1, 1, 0);

    // Reset asserted mid-cycle with a call pending; the call must be discarded.
    @(negedge clk);
    ncall = 1'b0; nwpc = 1'b1; nret = 1'b1; nrel = 1'b1; nincpc = 1'b1; nrpc = 1'b1;
    bus_en = 1'b1; bus_drv = 16'h7000;
    #2;
    push_exp("rst_mid", 16'hFFF0, 0, 1'b0, 1'b0, 1'b0);
    nreset = 1'b0;
    idle();
    nreset = 1'b1;
    step("post_rst", 0,0,0,0,0,0, 16'h0000, 16'hFFF0, 0, 0, 0);
    step("post_inc", 0,0,0,0,1,0, 16'h0000, 16'hFFF1, 0, 0, 0);
    idle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
